sun_scan_ctrl: RTL and testbench

- APB master sequencer that configures the sun-sensor accumulator peripheral and streams one frame of pixel intensities into it.
- Per frame it writes threshold, xmax and ymax, then issues a clear command.
- It then writes each pixel from an upstream valid/ready stream and finally reads back the accumulated sum.
- Sits between the pixel capture path and the sensor peripheral's APB slave port; software only pulses start and collects the sum.

---
 rtl/sun_pkg.sv | 34 +++
 rtl/sun_apb_mstr.sv | 96 +++++++++
 rtl/sun_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sun_scan_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sun_pkg.sv
// Shared definitions for the sun-sensor scan controller: accumulator
// register map, control command encoding and FSM state types.
package sun_pkg;

  localparam logic [31:0] ADDR_CTRL = 32'd0;
  localparam logic [31:0] ADDR_THR  = 32'd1;
  localparam logic [31:0] ADDR_XMAX = 32'd2;
  localparam logic [31:0] ADDR_YMAX = 32'd3;
  localparam logic [31:0] ADDR_PIX  = 32'd4;
  localparam logic [31:0] ADDR_STAT = 32'd5;
  localparam logic [31:0] ADDR_SUM  = 32'd6;

  localparam logic [31:0] CTRL_CLEAR = 32'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_THR,
    S_WR_XMAX,
    S_WR_YMAX,
    S_WR_CLR,
    S_PIX_WAIT,
    S_PIX_WR,
    S_GAP,
    S_RD_SUM,
    S_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS
  } apb_state_t;

endpackage

// File: rtl/sun_apb_mstr.sv
// Single-transfer APB master. A req pulse while idle launches one transfer;
// done pulses in the final ACCESS cycle with rdata valid alongside it.
// Optional macro SUN_SCAN_TIMEOUT_EN: ACCESS is force-terminated after
// TO_CYCLES cycles without pready, rdata reads as 0 and err is set sticky.
//
// state    | meaning
// A_IDLE   | bus idle, waiting for req
// A_SETUP  | psel=1, penable=0 for one cycle
// A_ACCESS | psel=1, penable=1 until pready (or timeout)
module sun_apb_mstr import sun_pkg::*; #(
  parameter int TO_CYCLES = 64
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  apb_state_t st, st_nxt;
  logic       to_hit;

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) st <= A_IDLE;
    else        st <= st_nxt;
  end

  // Address/data/direction captured at launch and held for the whole transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else if (st == A_IDLE && req) begin
      paddr  <= addr;
      pwdata <= wdata;
      pwrite <= wr;
    end
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    case (st)
      A_IDLE:   if (req) st_nxt = A_SETUP;
      A_SETUP:  st_nxt = A_ACCESS;
      A_ACCESS: if (pready || to_hit) st_nxt = A_IDLE;
      default:  st_nxt = A_IDLE;
    endcase
  end

  assign psel    = (st != A_IDLE);
  assign penable = (st == A_ACCESS);
  assign done    = (st == A_ACCESS) && (pready || to_hit);
  assign rdata   = to_hit ? '0 : prdata;

`ifdef SUN_SCAN_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Down-counter reloaded in SETUP; terminal count in ACCESS ends the transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (st == A_SETUP)
        to_cnt <= TO_W'(TO_CYCLES - 1);
      else if (st == A_ACCESS && to_cnt != '0)
        to_cnt <= to_cnt - TO_W'(1);
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign to_hit = (st == A_ACCESS) && !pready && (to_cnt == '0);
  assign err    = err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: rtl/sun_scan_ctrl.sv
// Frame sequencer for the sun-sensor accumulator: writes threshold and frame
// dimensions, clears the accumulator, streams pixels with a settling gap after
// each write, then reads back the frame sum.
// Optional macro SUN_SCAN_TIMEOUT_EN enables the APB pready timeout (err).
//
// state      | meaning
// S_IDLE     | waiting for start; cfg sampled on start
// S_WR_THR   | writing threshold
// S_WR_XMAX  | writing pixels per row
// S_WR_YMAX  | writing rows per frame
// S_WR_CLR   | writing clear command
// S_PIX_WAIT | pix_ready=1, waiting for a pixel handshake
// S_PIX_WR   | pixel write in flight
// S_GAP      | waiting PIX_GAP cycles for the slave pipeline
// S_RD_SUM   | reading the frame sum
// S_DONE     | sum_valid pulse
module sun_scan_ctrl import sun_pkg::*; #(
  parameter int PIX_GAP   = 4,
  parameter int DIM_W     = 16,
  parameter int TO_CYCLES = 64
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             start,
  input  logic [7:0]       cfg_thr,
  input  logic [DIM_W-1:0] cfg_xmax,
  input  logic [DIM_W-1:0] cfg_ymax,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [31:0]      paddr,
  output logic [31:0]      pwdata,
  input  logic [31:0]      prdata,
  input  logic             pready,
  output logic             busy,
  output logic             sum_valid,
  output logic [31:0]      sum_out,
  output logic             err
);

  // PIX_GAP must be at least 1.
  localparam int GAP_W = $clog2(PIX_GAP + 1);

  scan_state_t      state, state_nxt;
  logic [7:0]       thr_q;
  logic [DIM_W-1:0] xmax_q, ymax_q;
  logic [DIM_W-1:0] x_cnt, y_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_q;
  logic             issued_q;
  logic [31:0]      sum_q;

  logic             req, req_wr;
  logic [31:0]      req_addr, req_wdata;
  logic             apb_done;
  logic [31:0]      apb_rdata;

  sun_apb_mstr #(.TO_CYCLES(TO_CYCLES)) u_apb (
    .pclk    (pclk),
    .preset  (preset),
    .req     (req),
    .wr      (req_wr),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .done    (apb_done),
    .rdata   (apb_rdata),
    .err     (err),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready)
  );

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and transfer-request logic. Config/read transfers launch on
  // state entry (giving one idle bus cycle between transfers); a pixel write
  // launches in the handshake cycle so its SETUP lands in S_PIX_WR.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    req_wr    = 1'b1;
    req_addr  = ADDR_CTRL;
    req_wdata = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_WR_THR;
      S_WR_THR: begin
        req       = !issued_q;
        req_addr  = ADDR_THR;
        req_wdata = {24'd0, thr_q};
        if (apb_done) state_nxt = S_WR_XMAX;
      end
      S_WR_XMAX: begin
        req       = !issued_q;
        req_addr  = ADDR_XMAX;
        req_wdata = 32'(xmax_q);
        if (apb_done) state_nxt = S_WR_YMAX;
      end
      S_WR_YMAX: begin
        req       = !issued_q;
        req_addr  = ADDR_YMAX;
        req_wdata = 32'(ymax_q);
        if (apb_done) state_nxt = S_WR_CLR;
      end
      S_WR_CLR: begin
        req       = !issued_q;
        req_addr  = ADDR_CTRL;
        req_wdata = CTRL_CLEAR;
        if (apb_done)
          state_nxt = (xmax_q == '0 || ymax_q == '0) ? S_RD_SUM : S_PIX_WAIT;
      end
      S_PIX_WAIT: begin
        req_addr  = ADDR_PIX;
        req_wdata = {24'd0, pix_data};
        if (pix_valid) begin
          req       = 1'b1;
          state_nxt = S_PIX_WR;
        end
      end
      S_PIX_WR: if (apb_done) state_nxt = S_GAP;
      S_GAP: if (gap_cnt == '0) state_nxt = last_q ? S_RD_SUM : S_PIX_WAIT;
      S_RD_SUM: begin
        req      = !issued_q;
        req_wr   = 1'b0;
        req_addr = ADDR_SUM;
        if (apb_done) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow configuration, sampled only when a frame starts.
  always_ff @(posedge pclk) begin
    if (preset) begin
      thr_q  <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
    end else if (state == S_IDLE && start) begin
      thr_q  <= cfg_thr;
      xmax_q <= cfg_xmax;
      ymax_q <= cfg_ymax;
    end
  end

  // Tracks whether the current state's transfer has already been launched.
  always_ff @(posedge pclk) begin
    if (preset)        issued_q <= 1'b0;
    else if (apb_done) issued_q <= 1'b0;
    else if (req)      issued_q <= 1'b1;
  end

  // Pixel position counters and last-pixel flag, advanced per completed write.
  always_ff @(posedge pclk) begin
    if (preset) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      last_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      last_q <= 1'b0;
    end else if (state == S_PIX_WR && apb_done) begin
      if (x_cnt == xmax_q - DIM_W'(1)) begin
        x_cnt  <= '0;
        y_cnt  <= y_cnt + DIM_W'(1);
        last_q <= (y_cnt + DIM_W'(1) == ymax_q);
      end else begin
        x_cnt  <= x_cnt + DIM_W'(1);
        last_q <= 1'b0;
      end
    end
  end

  // Settling gap down-counter, loaded as each pixel write completes.
  always_ff @(posedge pclk) begin
    if (preset)
      gap_cnt <= '0;
    else if (state == S_PIX_WR && apb_done)
      gap_cnt <= GAP_W'(PIX_GAP - 1);
    else if (state == S_GAP && gap_cnt != '0)
      gap_cnt <= gap_cnt - GAP_W'(1);
  end

  // Frame sum capture on completion of the read.
  always_ff @(posedge pclk) begin
    if (preset)                          sum_q <= '0;
    else if (state == S_RD_SUM && apb_done) sum_q <= apb_rdata;
  end

  assign pix_ready = (state == S_PIX_WAIT);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign sum_valid = (state == S_DONE);
  assign sum_out   = sum_q;

endmodule

// File: tb/tb_sun_scan_ctrl.sv
module tb_sun_scan_ctrl;

`ifdef SUN_SCAN_TIMEOUT_EN
  localparam int TO_C = 8;
`else
  localparam int TO_C = 64;
`endif

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_thr = '0;
  logic [15:0] cfg_xmax = '0;
  logic [15:0] cfg_ymax = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready = 1'b0;
  logic        busy, sum_valid, err;
  logic [31:0] sum_out;

  sun_scan_ctrl #(.PIX_GAP(4), .DIM_W(16), .TO_CYCLES(TO_C)) dut (
    .pclk(pclk), .preset(preset), .start(start), .cfg_thr(cfg_thr),
    .cfg_xmax(cfg_xmax), .cfg_ymax(cfg_ymax), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .busy(busy), .sum_valid(sum_valid), .sum_out(sum_out),
    .err(err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          pix_setups[$];
  logic [7:0]  pix_q[$];
  int          pix_idx = 0;
  bit          hs = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          slv_wait = 0;
  bit          slv_hang_rd = 0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;
  int          rd_acc_len = 0;
  bit          pix_ready_seen = 0;

  assign prdata = slv_rdata;

  // Scoreboard on every SETUP phase, plus slave pready model.
  always @(negedge pclk) begin
    txn_t t;
    cyc++;
    if (pix_ready) pix_ready_seen = 1;
    if (psel && !penable) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL apb_unexpected: got wr=%0b addr=%0d data=%0d, none expected",
                 pwrite, paddr, pwdata);
      end else begin
        t = exp_q.pop_front();
        if (pwrite !== t.wr || paddr !== t.addr || (t.wr && pwdata !== t.data))
          $display("FAIL apb_txn: got wr=%0b addr=%0d data=%0d want wr=%0b addr=%0d data=%0d",
                   pwrite, paddr, pwdata, t.wr, t.addr, t.data);
        else
          n_pass++;
      end
      if (paddr == 32'd4) pix_setups.push_back(cyc);
    end
    if (psel && penable) begin
      pready = !(slv_hang_rd && !pwrite) && (acc_cnt >= slv_wait);
      acc_cnt++;
      if (!pwrite) rd_acc_len = acc_cnt;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
  end

  // Pixel source: holds pix_valid while pixels remain, advances on handshake.
  always @(negedge pclk) begin
    if (hs) pix_idx++;
    if (pix_idx < pix_q.size()) begin
      pix_valid = 1'b1;
      pix_data  = pix_q[pix_idx];
    end else begin
      pix_valid = 1'b0;
      pix_data  = '0;
    end
    hs = pix_valid && pix_ready;
  end

  task automatic exp_wr(input int a, input int d);
    txn_t t;
    t.wr = 1'b1; t.addr = 32'(a); t.data = 32'(d);
    exp_q.push_back(t);
  endtask

  task automatic exp_rd();
    txn_t t;
    t.wr = 1'b0; t.addr = 32'd6; t.data = '0;
    exp_q.push_back(t);
  endtask

  task automatic exp_cfg(input int thr, input int xm, input int ym);
    exp_wr(1, thr);
    exp_wr(2, xm);
    exp_wr(3, ym);
    exp_wr(0, 1);
  endtask

  task automatic do_start(input int thr, input int xm, input int ym);
    @(negedge pclk);
    cfg_thr  = 8'(thr);
    cfg_xmax = 16'(xm);
    cfg_ymax = 16'(ym);
    start    = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_sum(input int max_cyc, output bit got);
    got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge pclk);
      if (sum_valid) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    n_checks++;
    if ({psel, penable, pwrite} !== 3'b000)
      $display("FAIL reset_apb_ctl: got %b want 000", {psel, penable, pwrite});
    else n_pass++;
    n_checks++;
    if (paddr !== 32'd0 || pwdata !== 32'd0)
      $display("FAIL reset_apb_bus: got addr=%0d data=%0d want 0", paddr, pwdata);
    else n_pass++;
    n_checks++;
    if ({busy, sum_valid, pix_ready, err} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {busy, sum_valid, pix_ready, err});
    else n_pass++;
    n_checks++;
    if (sum_out !== 32'd0) $display("FAIL reset_sum: got %0d want 0", sum_out);
    else n_pass++;
    preset = 1'b0;
  endtask

  task automatic test_basic();
    bit got;
    exp_q.delete();
    exp_cfg(10, 2, 2);
    exp_wr(4, 5); exp_wr(4, 20); exp_wr(4, 30); exp_wr(4, 8);
    exp_rd();
    pix_q = '{8'd5, 8'd20, 8'd30, 8'd8};
    pix_idx = 0;
    slv_wait = 1;
    slv_rdata = 32'd50;
    do_start(10, 2, 2);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else n_pass++;
    wait_sum(500, got);
    n_checks++;
    if (!got) $display("FAIL basic_sum_valid: got no pulse want pulse");
    else n_pass++;
    n_checks++;
    if (sum_out !== 32'd50 || busy !== 1'b0)
      $display("FAIL basic_sum: got sum=%0d busy=%b want sum=50 busy=0", sum_out, busy);
    else n_pass++;
    @(negedge pclk);
    n_checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_pulse_len: got sum_valid=%b busy=%b want 0 0", sum_valid, busy);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || pix_idx != 4)
      $display("FAIL basic_drain: got pending=%0d pixels=%0d want 0 4", exp_q.size(), pix_idx);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_gap();
    bit got;
    exp_q.delete();
    exp_cfg(1, 3, 1);
    exp_wr(4, 1); exp_wr(4, 2); exp_wr(4, 3);
    exp_rd();
    pix_q = '{8'd1, 8'd2, 8'd3};
    pix_idx = 0;
    slv_wait = 0;
    slv_rdata = 32'd6;
    pix_setups.delete();
    do_start(1, 3, 1);
    wait_sum(500, got);
    n_checks++;
    if (!got || sum_out !== 32'd6)
      $display("FAIL gap_sum: got pulse=%0b sum=%0d want 1 6", got, sum_out);
    else n_pass++;
    n_checks++;
    if (pix_setups.size() != 3) begin
      $display("FAIL gap_count: got %0d pixel writes want 3", pix_setups.size());
    end else begin
      if (pix_setups[1] - pix_setups[0] != 7 || pix_setups[2] - pix_setups[1] != 7)
        $display("FAIL gap_cycles: got %0d,%0d want 7,7",
                 pix_setups[1] - pix_setups[0], pix_setups[2] - pix_setups[1]);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    bit got;
    exp_q.delete();
    exp_cfg(7, 0, 3);
    exp_rd();
    pix_q = '{8'd9};
    pix_idx = 0;
    slv_rdata = 32'd123;
    pix_ready_seen = 0;
    do_start(7, 0, 3);
    wait_sum(300, got);
    n_checks++;
    if (!got || sum_out !== 32'd123)
      $display("FAIL zero_sum: got pulse=%0b sum=%0d want 1 123", got, sum_out);
    else n_pass++;
    n_checks++;
    if (pix_ready_seen || pix_idx != 0 || exp_q.size() != 0)
      $display("FAIL zero_no_pixels: got ready_seen=%0b taken=%0d pending=%0d want 0 0 0",
               pix_ready_seen, pix_idx, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    bit got;
    exp_q.delete();
    exp_cfg(3, 2, 1);
    exp_wr(4, 7); exp_wr(4, 9);
    exp_rd();
    pix_q = '{8'd7, 8'd9};
    pix_idx = 0;
    slv_wait = 1;
    slv_rdata = 32'd16;
    do_start(3, 2, 1);
    repeat (6) @(negedge pclk);
    do_start(99, 5, 5);
    wait_sum(500, got);
    n_checks++;
    if (!got || sum_out !== 32'd16)
      $display("FAIL restart_sum: got pulse=%0b sum=%0d want 1 16", got, sum_out);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || pix_idx != 2)
      $display("FAIL restart_dims: got pending=%0d pixels=%0d want 0 2", exp_q.size(), pix_idx);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit got;
    bit found;
    exp_q.delete();
    exp_cfg(4, 2, 2);
    exp_wr(4, 1); exp_wr(4, 2); exp_wr(4, 3); exp_wr(4, 4);
    exp_rd();
    pix_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    pix_idx = 0;
    slv_wait = 3;
    pix_setups.delete();
    do_start(4, 2, 2);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge pclk);
      if (pix_setups.size() == 3 && psel && penable) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL abort_reach_pix3: got no ACCESS of pixel 3 want one");
    else n_pass++;
    preset = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0 || sum_valid !== 1'b0)
      $display("FAIL abort_idle: got psel=%b penable=%b busy=%b sum_valid=%b want 0 0 0 0",
               psel, penable, busy, sum_valid);
    else n_pass++;
    preset = 1'b0;
    exp_q.delete();
    exp_cfg(6, 1, 1);
    exp_wr(4, 42);
    exp_rd();
    pix_q = '{8'd42};
    pix_idx = 0;
    slv_wait = 0;
    slv_rdata = 32'd42;
    do_start(6, 1, 1);
    wait_sum(300, got);
    n_checks++;
    if (!got || sum_out !== 32'd42 || exp_q.size() != 0)
      $display("FAIL abort_restart: got pulse=%0b sum=%0d pending=%0d want 1 42 0",
               got, sum_out, exp_q.size());
    else n_pass++;
  endtask

`ifdef SUN_SCAN_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    exp_q.delete();
    exp_cfg(2, 1, 1);
    exp_wr(4, 3);
    exp_rd();
    pix_q = '{8'd3};
    pix_idx = 0;
    slv_wait = 0;
    slv_hang_rd = 1;
    slv_rdata = 32'd77;
    rd_acc_len = 0;
    do_start(2, 1, 1);
    wait_sum(400, got);
    n_checks++;
    if (!got || sum_out !== 32'd0)
      $display("FAIL timeout_sum: got pulse=%0b sum=%0d want 1 0", got, sum_out);
    else n_pass++;
    n_checks++;
    if (rd_acc_len != 8 || err !== 1'b1)
      $display("FAIL timeout_len: got access=%0d err=%b want 8 1", rd_acc_len, err);
    else n_pass++;
    slv_hang_rd = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_zero();
    test_restart_ignored();
    test_abort();
`ifdef SUN_SCAN_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
